// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter that shares one 8:1 single-bit mux output among eight requesters.
// The burst length per grant is capped at MAX_BURST cycles; the released requester gets lowest priority.
module rr_mux8_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] din,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       y,
  output logic       valid
);

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_d;
  logic [IDX_W-1:0]   sel_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   arb_ptr;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rearb;
  logic               rel;
  logic [IDX_W:0]     pick_res;

  // Returns {found, index} of the first set request searching from p upward with wrap.
  function automatic logic [IDX_W:0] pick(input logic [N_REQ-1:0] r, input logic [IDX_W-1:0] p);
    logic             found;
    logic [IDX_W-1:0] res;
    logic [IDX_W-1:0] idx;
    found = 1'b0;
    res   = p;
    idx   = p;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = IDX_W'(p + IDX_W'(i));
      if (!found && r[idx]) begin
        found = 1'b1;
        res   = idx;
      end
    end
    return {found, res};
  endfunction

  assign rel      = !req[sel] || (cnt_q == CNT_W'(MAX_BURST - 1));
  assign pick_res = pick(req, arb_ptr);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    sel_d   = sel;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    arb_ptr = ptr_q;
    rearb   = 1'b0;

    case (state_q)
      IDLE: rearb = 1'b1;
      GRANT: begin
        if (rel) begin
          // Rotate past the released requester and re-arbitrate in the same edge.
          ptr_d   = IDX_W'(sel + IDX_W'(1));
          arb_ptr = IDX_W'(sel + IDX_W'(1));
          rearb   = 1'b1;
        end else begin
          cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        end
      end
      default: state_d = IDLE;
    endcase

    if (rearb) begin
      if (pick_res[IDX_W]) begin
        gnt_d   = N_REQ'(1) << pick_res[IDX_W-1:0];
        sel_d   = pick_res[IDX_W-1:0];
        cnt_d   = '0;
        state_d = GRANT;
      end else begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt     <= '0;
      sel     <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign valid = (state_q == GRANT);
  assign y     = valid & din[sel];

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Directed bench for rr_mux8_arbiter: per-cycle expectations are queued by the stimulus
// process and checked by an independent monitor on the falling edge.
module tb_rr_mux8_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] din;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       y;
  logic       valid;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic       y;
  } exp_t;

  exp_t exp_q[$];

  rr_mux8_arbiter #(.MAX_BURST(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .din   (din),
    .gnt   (gnt),
    .sel   (sel),
    .y     (y),
    .valid (valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Apply inputs for one cycle and queue the outputs expected during that cycle.
  task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] d,
                      input logic [7:0] eg, input logic [2:0] es, input logic ev, input logic ey);
    exp_t e;
    rst = r;
    req = rq;
    din = d;
    e.gnt   = eg;
    e.sel   = es;
    e.valid = ev;
    e.y     = ey;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (gnt !== e.gnt || sel !== e.sel || valid !== e.valid || y !== e.y) begin
          errors++;
          $display("FAIL out_chk t=%0t: got gnt=%h sel=%0d valid=%b y=%b, want gnt=%h sel=%0d valid=%b y=%b",
                   $time, gnt, sel, valid, y, e.gnt, e.sel, e.valid, e.y);
        end
      end
    end
  end

  initial begin
    logic [7:0] dv;
    int unsigned g;
    rst = 1'b1;
    req = 8'hFF;
    din = 8'hFF;
    @(posedge clk);
    #1;

    // Reset held with all requests high, then first grant goes to requester 0.
    step(1'b1, 8'hFF, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0);
    step(1'b0, 8'hFF, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b1);
    step(1'b0, 8'h00, 8'h08, 8'h00, 3'd0, 1'b0, 1'b0);

    // Single short request from requester 3.
    step(1'b0, 8'h08, 8'h08, 8'h00, 3'd0, 1'b0, 1'b0);
    step(1'b0, 8'h08, 8'h08, 8'h08, 3'd3, 1'b1, 1'b1);
    step(1'b0, 8'h00, 8'h08, 8'h08, 3'd3, 1'b1, 1'b1);
    step(1'b0, 8'h00, 8'h08, 8'h00, 3'd3, 1'b0, 1'b0);

    // Wrap-around: ptr=4, requesters 0 and 2 pending; 0 bursts 4 cycles then 2.
    step(1'b0, 8'h05, 8'h04, 8'h00, 3'd3, 1'b0, 1'b0);
    step(1'b0, 8'h05, 8'h04, 8'h01, 3'd0, 1'b1, 1'b0);
    step(1'b0, 8'h05, 8'h04, 8'h01, 3'd0, 1'b1, 1'b0);
    step(1'b0, 8'h05, 8'h04, 8'h01, 3'd0, 1'b1, 1'b0);
    step(1'b0, 8'h05, 8'h04, 8'h01, 3'd0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1);
    step(1'b0, 8'h00, 8'h04, 8'h00, 3'd2, 1'b0, 1'b0);

    // Full load: reset pointer, then 0..7 each for exactly 4 cycles, no gaps.
    dv = 8'b1011_0111;
    step(1'b1, 8'h00, dv, 8'h00, 3'd2, 1'b0, 1'b0);
    step(1'b0, 8'hFF, dv, 8'h00, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 32; k++) begin
      g = (k / 4) % 8;
      step(1'b0, 8'hFF, dv, 8'(1) << g, 3'(g), 1'b1, dv[g]);
    end
    // Wrapped back to 0; dropping its request hands the line to requester 5.
    step(1'b0, 8'h20, dv, 8'h01, 3'd0, 1'b1, 1'b1);

    // Sole requester 5 times out repeatedly but keeps the grant continuously.
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 8'h20, dv, 8'h20, 3'd5, 1'b1, 1'b1);
    end
    step(1'b0, 8'h00, dv, 8'h20, 3'd5, 1'b1, 1'b1);
    step(1'b0, 8'h00, dv, 8'h00, 3'd5, 1'b0, 1'b0);

    // Reset mid-grant of requester 6; regranted one cycle after reset falls.
    step(1'b0, 8'hC0, dv, 8'h00, 3'd5, 1'b0, 1'b0);
    step(1'b0, 8'hC0, dv, 8'h40, 3'd6, 1'b1, 1'b0);
    step(1'b1, 8'hC0, dv, 8'h40, 3'd6, 1'b1, 1'b0);
    step(1'b0, 8'hC0, dv, 8'h00, 3'd0, 1'b0, 1'b0);
    step(1'b0, 8'hC0, dv, 8'h40, 3'd6, 1'b1, 1'b0);
    step(1'b0, 8'h80, dv, 8'h40, 3'd6, 1'b1, 1'b0);
    step(1'b0, 8'h80, dv, 8'h80, 3'd7, 1'b1, 1'b1);
    // y follows din combinationally while granted.
    step(1'b0, 8'h00, 8'h7F, 8'h80, 3'd7, 1'b1, 1'b0);
    step(1'b0, 8'h00, 8'hFF, 8'h00, 3'd7, 1'b0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
